mem_io_bridge: RTL and testbench
================================

// Module: mem_io_bridge
// PURPOSE
//  Parametrised memory/MMIO bridge between the CPU load/store path and data memory plus board I/O.
//  Decodes the ALU address: below IO_BASE goes to dmem; IO_BASE..IO_BASE+0xFF goes to peripheral registers.
//  Owns the synchronised switch/button inputs, button edge latches, LED and 7-seg output registers.
//  Returns a single load word with the same 1-cycle latency as the synchronous dmem.
// PARAMETERS
//  IO_BASE      32'hFFFF_FC00  base of I/O window; window is 256 bytes, word-aligned
//  SW_WIDTH     16             switch inputs (1..32)
//  LED_WIDTH    16             LED outputs (1..32)
//  BTN_COUNT    5              push buttons (1..16)
//  SYNC_STAGES  2              synchroniser flops per async input (>=2)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous, active-low reset
//  mem_read     in   1          load strobe from controller
//  mem_write    in   1          store strobe from controller
//  addr_in      in   32         byte address (alu_result)
//  wdata_in     in   32         store data (register file rt)
//  rdata_out    out  32         load data to write-back, valid the cycle after mem_read
//  dmem_addr    out  32         address to data memory (= addr_in)
//  dmem_we      out  1          dmem write enable
//  dmem_wdata   out  32         = wdata_in
//  dmem_rdata   in   32         synchronous dmem read data (1-cycle latency)
//  sw_in        in   SW_WIDTH   raw switches (async)
//  btn_in       in   BTN_COUNT  raw buttons (async, active-high)
//  led_out      out  LED_WIDTH  LED register
//  seg_value    out  32         8 hex digits for the 7-seg driver
//  bus_err      out  1          1-cycle pulse on access to unmapped I/O offset
// BEHAVIOUR
//  Decode: is_io = (addr_in & ~32'hFF) == IO_BASE; offset = addr_in[7:0]; low 2 bits ignored.
//  dmem_we = mem_write & ~is_io (combinational). mem_read & mem_write together: write wins, no read.
//  I/O map (offset: access):
//   0x00 SW    R   {0, sw_sync}
//   0x04 BTN   R   {0, btn_sync} current level
//   0x08 EDGE  R/W rising-edge latches; read returns and clears; write-1-to-clear per bit
//   0x10 LED   R/W led_out <= wdata_in[LED_WIDTH-1:0]
//   0x14 SEG   R/W seg_value <= wdata_in
//   other: read 0, write ignored, bus_err pulses next cycle
//  Read timing: on mem_read, register is_io and offset (rd_sel) plus I/O data (io_rdata_q) at clk edge;
//   next cycle rdata_out = rd_sel_io ? io_rdata_q : dmem_rdata. Combinational mux on registered select only.
//  Stores to I/O take effect at the clk edge of the mem_write cycle; readback visible on the following load.
//  Sync: each sw/btn bit passes SYNC_STAGES flops; edge = btn_sync & ~btn_sync_d.
//  EDGE latch per bit: set on edge; cleared by EDGE read or W1C. Same-cycle set and clear: set wins (bit stays 1,
//   read returns pre-clear value). Edge during reset is not captured.
//  Reset (rst_n=0, any cycle incl. mid-access): led_out=0, seg_value=0, edge latches=0, sync chains=0,
//   rd_sel=dmem, io_rdata_q=0, rdata_out follows dmem_rdata, bus_err=0. Pending load is dropped.
//  Widths: narrower fields zero-extended on read; upper wdata bits discarded on write.
// STRUCTURE
//  Package mem_io_pkg: offset constants OFF_SW/OFF_BTN/OFF_EDGE/OFF_LED/OFF_SEG, IO_WINDOW_MASK.
//  Sub-module io_sync_edge (param WIDTH, STAGES): synchroniser + rising-edge pulse; one instance each
//   for switches (edge unused) and buttons.
//  Top: decoder, I/O register file, edge latches, read-select pipeline register, output mux.
// TESTING
//  1 reset: rst_n=0 with sw_in=16'hFFFF -> led_out=0, seg_value=0, rdata_out=dmem_rdata, bus_err=0.
//  2 store 0x0000_A5A5 @IO_BASE+0x10 -> led_out=16'hA5A5 next edge; load same addr -> 0x0000_A5A5 one cycle later.
//  3 sw_in=16'h1234, wait SYNC_STAGES+1 cycles, load @IO_BASE+0x00 -> rdata_out=0x0000_1234; earlier load -> 0.
//  4 pulse btn_in[2] 3 cycles -> EDGE read =0x4, second read =0x0; edge coincident with read -> read 0x4, bit stays set.
//  5 store @0x0000_0040 -> dmem_we=1, led/seg unchanged; load @IO_BASE+0x3C -> rdata_out=0, bus_err pulse 1 cycle.
//  6 assert rst_n=0 the cycle after an I/O load issues -> rdata_out selects dmem, edge latches and LED cleared.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants and decode helper for the memory/MMIO bridge.
package mem_io_pkg;

    // Byte offsets of the peripheral registers inside the I/O window.
    localparam logic [7:0] OFF_SW   = 8'h00;
    localparam logic [7:0] OFF_BTN  = 8'h04;
    localparam logic [7:0] OFF_EDGE = 8'h08;
    localparam logic [7:0] OFF_LED  = 8'h10;
    localparam logic [7:0] OFF_SEG  = 8'h14;

    // Clears the in-window offset so the base can be compared directly.
    localparam logic [31:0] IO_WINDOW_MASK = 32'hFFFF_FF00;

    typedef enum logic [2:0] {
        RegSw,
        RegBtn,
        RegEdge,
        RegLed,
        RegSeg,
        RegNone
    } io_reg_e;

    // Map a word-aligned offset onto the register it selects.
    function automatic io_reg_e decode_reg(input logic [7:0] offset);
        io_reg_e sel;
        case (offset)
            OFF_SW:   sel = RegSw;
            OFF_BTN:  sel = RegBtn;
            OFF_EDGE: sel = RegEdge;
            OFF_LED:  sel = RegLed;
            OFF_SEG:  sel = RegSeg;
            default:  sel = RegNone;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Multi-flop synchroniser for asynchronous board inputs with a rising-edge pulse.
module io_sync_edge #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_out
);

    // Element 0 is the metastability-catching flop; element STAGES-1 is the clean output.
    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0]             sync_d_q;

    // Shift the raw input through the chain and keep one delayed copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q  <= '0;
            sync_d_q <= '0;
        end else begin
            chain_q  <= {chain_q[STAGES-2:0], async_in};
            sync_d_q <= chain_q[STAGES-1];
        end
    end

    assign sync_out = chain_q[STAGES-1];
    assign rise_out = chain_q[STAGES-1] & ~sync_d_q;

endmodule

// File: rtl/mem_io_bridge.sv
// Load/store bridge: splits CPU accesses between synchronous dmem and the board I/O registers.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FC00,
    parameter int unsigned SW_WIDTH    = 16,
    parameter int unsigned LED_WIDTH   = 16,
    parameter int unsigned BTN_COUNT   = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          addr_in,
    input  logic [31:0]          wdata_in,
    output logic [31:0]          rdata_out,
    output logic [31:0]          dmem_addr,
    output logic                 dmem_we,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic [SW_WIDTH-1:0]  sw_in,
    input  logic [BTN_COUNT-1:0] btn_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic [31:0]          seg_value,
    output logic                 bus_err
);

    logic                 is_io;
    logic [7:0]           offset;
    io_reg_e              reg_sel;
    logic                 rd_en;
    logic                 io_rd;
    logic                 io_wr;
    logic [SW_WIDTH-1:0]  sw_sync;
    logic [SW_WIDTH-1:0]  sw_rise_unused;
    logic [BTN_COUNT-1:0] btn_sync;
    logic [BTN_COUNT-1:0] btn_rise;
    logic [BTN_COUNT-1:0] edge_q, edge_d, edge_clr;
    logic [LED_WIDTH-1:0] led_q;
    logic [31:0]          seg_q;
    logic [31:0]          io_rdata_d, io_rdata_q;
    logic                 rd_sel_io_q;
    logic                 bus_err_q;

    io_sync_edge #(
        .WIDTH  (SW_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sw_in),
        .sync_out (sw_sync),
        .rise_out (sw_rise_unused)
    );

    io_sync_edge #(
        .WIDTH  (BTN_COUNT),
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (btn_in),
        .sync_out (btn_sync),
        .rise_out (btn_rise)
    );

    // Address decode; the low two address bits never select a register.
    assign is_io   = (addr_in & IO_WINDOW_MASK) == IO_BASE;
    assign offset  = {addr_in[7:2], 2'b00};
    assign reg_sel = decode_reg(offset);
    // A simultaneous read and write is treated as a write only.
    assign rd_en   = mem_read & ~mem_write;
    assign io_rd   = rd_en & is_io;
    assign io_wr   = mem_write & is_io;

    assign dmem_addr  = addr_in;
    assign dmem_wdata = wdata_in;
    assign dmem_we    = mem_write & ~is_io;

    // Select the I/O read value; narrow registers are zero-extended.
    always_comb begin
        io_rdata_d = '0;
        case (reg_sel)
            RegSw:   io_rdata_d = 32'(sw_sync);
            RegBtn:  io_rdata_d = 32'(btn_sync);
            RegEdge: io_rdata_d = 32'(edge_q);
            RegLed:  io_rdata_d = 32'(led_q);
            RegSeg:  io_rdata_d = seg_q;
            default: io_rdata_d = '0;
        endcase
    end

    // Edge latches: read clears all, write clears ones; a new edge always wins over a clear.
    always_comb begin
        edge_clr = '0;
        if (reg_sel == RegEdge) begin
            if (io_rd) begin
                edge_clr = '1;
            end else if (io_wr) begin
                edge_clr = wdata_in[BTN_COUNT-1:0];
            end
        end
        edge_d = (edge_q & ~edge_clr) | btn_rise;
    end

    // Peripheral register file, read pipeline and bus-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q       <= '0;
            seg_q       <= '0;
            edge_q      <= '0;
            rd_sel_io_q <= 1'b0;
            io_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            edge_q      <= edge_d;
            rd_sel_io_q <= io_rd;
            bus_err_q   <= is_io & (mem_read | mem_write) & (reg_sel == RegNone);
            if (io_wr && reg_sel == RegLed) begin
                led_q <= wdata_in[LED_WIDTH-1:0];
            end
            if (io_wr && reg_sel == RegSeg) begin
                seg_q <= wdata_in;
            end
            if (io_rd) begin
                io_rdata_q <= io_rdata_d;
            end
        end
    end

    // Match dmem's one-cycle latency by muxing on the registered select only.
    assign rdata_out = rd_sel_io_q ? io_rdata_q : dmem_rdata;
    assign led_out   = led_q;
    assign seg_value = seg_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: cycle-level reference model plus directed literal checks.
module tb_mem_io_bridge;

    localparam logic [31:0] IO   = 32'hFFFF_FC00;
    localparam int          S    = 2;
    localparam int          LOGN = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] addr_in = '0, wdata_in = '0, dmem_rdata = '0;
    logic [31:0] rdata_out, dmem_addr, dmem_wdata, seg_value;
    logic        dmem_we, bus_err;
    logic [15:0] sw_in = '0, led_out;
    logic [4:0]  btn_in = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    mem_io_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .rdata_out  (rdata_out),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .sw_in      (sw_in),
        .btn_in     (btn_in),
        .led_out    (led_out),
        .seg_value  (seg_value),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] led;
        logic [31:0] seg;
        logic [4:0]  edges;
        logic        sel_io;
        logic [31:0] io_q;
        logic        err;
    } model_t;

    model_t      m = '{led: '0, seg: '0, edges: '0, sel_io: 1'b0, io_q: '0, err: 1'b0};
    logic [31:0] sw_log  [LOGN];
    logic [31:0] btn_log [LOGN];
    int          cyc = 0;
    int          last_rst = 0;

    // Value seen by the core after posedge k: input sampled S-1 posedges earlier, 0 if reset since.
    function automatic logic [31:0] sw_at(int k);
        int idx;
        idx = k - S + 1;
        if (idx <= last_rst) return '0;
        return sw_log[idx % LOGN];
    endfunction

    function automatic logic [31:0] btn_at(int k);
        int idx;
        idx = k - S + 1;
        if (idx <= last_rst) return '0;
        return btn_log[idx % LOGN];
    endfunction

    function automatic model_t model_next(model_t cur, int k);
        model_t      nx;
        logic [31:0] btv, val, clr;
        logic        io, rd, mapped;
        int          off;
        nx     = cur;
        btv    = btn_at(k);
        io     = (addr_in >= IO) && (addr_in <= IO + 32'd255);
        off    = int'((addr_in - IO) & 32'h0000_00FC);
        rd     = mem_read && !mem_write;
        val    = '0;
        clr    = '0;
        mapped = 1'b1;
        if (io) begin
            case (off)
                0:  val = sw_at(k);
                4:  val = btv;
                8:  begin
                        val = 32'(cur.edges);
                        if (rd) clr = '1;
                        else if (mem_write) clr = wdata_in;
                    end
                16: begin
                        val = 32'(cur.led);
                        if (mem_write) nx.led = wdata_in[15:0];
                    end
                20: begin
                        val = cur.seg;
                        if (mem_write) nx.seg = wdata_in;
                    end
                default: mapped = 1'b0;
            endcase
        end
        nx.edges  = (cur.edges & ~clr[4:0]) | (btv[4:0] & ~btn_at(k - 1)[4:0]);
        nx.sel_io = rd && io;
        if (rd && io) nx.io_q = val;
        nx.err = io && (mem_read || mem_write) && !mapped;
        return nx;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m        <= '{led: '0, seg: '0, edges: '0, sel_io: 1'b0, io_q: '0, err: 1'b0};
            last_rst <= cyc + 1;
        end else begin
            sw_log[(cyc + 1) % LOGN]  <= 32'(sw_in);
            btn_log[(cyc + 1) % LOGN] <= 32'(btn_in);
            m <= model_next(m, cyc);
        end
    end

    // Every cycle: DUT outputs against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata_out", rdata_out, m.sel_io ? m.io_q : dmem_rdata);
            chk("led_out", 32'(led_out), 32'(m.led));
            chk("seg_value", seg_value, m.seg);
            chk("bus_err", 32'(bus_err), 32'(m.err));
            chk("dmem_we", 32'(dmem_we),
                32'(mem_write && !((addr_in >= IO) && (addr_in <= IO + 32'd255))));
            chk("dmem_addr", dmem_addr, addr_in);
            chk("dmem_wdata", dmem_wdata, wdata_in);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] w);
        mem_read  = rd;
        mem_write = wr;
        addr_in   = a;
        wdata_in  = w;
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic press_release();
        btn_in[2] = 1'b1;
        repeat (3) step();
        btn_in[2] = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        dmem_rdata = 32'hDEAD_BEEF;
        sw_in      = 16'hFFFF;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        step();
        // 1 reset state
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_seg", seg_value, 32'h0);
        chk("rst_rdata", rdata_out, 32'hDEAD_BEEF);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        rst_n = 1'b1;
        sw_in = '0;
        repeat (3) step();

        // 2 LED / SEG store and readback
        access(1'b0, 1'b1, IO + 32'h10, 32'h0000_A5A5);
        chk("led_store", 32'(led_out), 32'h0000_A5A5);
        access(1'b1, 1'b0, IO + 32'h10, 32'h0);
        chk("led_load", rdata_out, 32'h0000_A5A5);
        access(1'b0, 1'b1, IO + 32'h17, 32'h1234_5678);
        chk("seg_store_unaligned", seg_value, 32'h1234_5678);
        access(1'b1, 1'b0, IO + 32'h14, 32'h0);
        chk("seg_load", rdata_out, 32'h1234_5678);

        // plain dmem load, and read+write together (write wins)
        dmem_rdata = 32'h1357_9BDF;
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        chk("dmem_load", rdata_out, 32'h1357_9BDF);
        access(1'b1, 1'b1, IO + 32'h10, 32'h0000_00FF);
        chk("rw_led", 32'(led_out), 32'h0000_00FF);
        chk("rw_no_read", rdata_out, 32'h1357_9BDF);

        // 3 switch synchronisation
        sw_in = 16'h1234;
        access(1'b1, 1'b0, IO + 32'h00, 32'h0);
        chk("sw_early", rdata_out, 32'h0);
        step();
        access(1'b1, 1'b0, IO + 32'h00, 32'h0);
        chk("sw_sync", rdata_out, 32'h0000_1234);

        // 4 button edge latches
        btn_in[2] = 1'b1;
        repeat (3) step();
        access(1'b1, 1'b0, IO + 32'h04, 32'h0);
        chk("btn_level", rdata_out, 32'h4);
        btn_in[2] = 1'b0;
        access(1'b1, 1'b0, IO + 32'h08, 32'h0);
        chk("edge_read", rdata_out, 32'h4);
        access(1'b1, 1'b0, IO + 32'h08, 32'h0);
        chk("edge_cleared", rdata_out, 32'h0);
        repeat (3) step();
        press_release();
        btn_in[2] = 1'b1;
        repeat (2) step();
        access(1'b1, 1'b0, IO + 32'h08, 32'h0);
        chk("edge_coincident", rdata_out, 32'h4);
        access(1'b1, 1'b0, IO + 32'h08, 32'h0);
        chk("edge_set_wins", rdata_out, 32'h4);
        btn_in[2] = 1'b0;
        repeat (4) step();
        press_release();
        access(1'b0, 1'b1, IO + 32'h08, 32'h0000_0004);
        access(1'b1, 1'b0, IO + 32'h08, 32'h0);
        chk("edge_w1c", rdata_out, 32'h0);

        // 5 dmem store outside window, unmapped I/O load
        mem_write = 1'b1;
        addr_in   = 32'h0000_0040;
        wdata_in  = 32'hCAFE_F00D;
        #1;
        chk("dmem_we", 32'(dmem_we), 32'h1);
        step();
        mem_write = 1'b0;
        chk("dmem_store_led", 32'(led_out), 32'h0000_00FF);
        chk("dmem_store_seg", seg_value, 32'h1234_5678);
        access(1'b1, 1'b0, IO + 32'h3C, 32'h0);
        chk("unmapped_rdata", rdata_out, 32'h0);
        chk("bus_err_pulse", 32'(bus_err), 32'h1);
        step();
        chk("bus_err_end", 32'(bus_err), 32'h0);

        // 6 reset right after an I/O load issues
        press_release();
        dmem_rdata = 32'h0BAD_F00D;
        access(1'b1, 1'b0, IO + 32'h10, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata", rdata_out, 32'h0BAD_F00D);
        chk("midrst_led", 32'(led_out), 32'h0);
        chk("midrst_seg", seg_value, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        access(1'b1, 1'b0, IO + 32'h08, 32'h0);
        chk("midrst_edge", rdata_out, 32'h0);
        repeat (2) step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
